// File: rtl/mem_access_unit.sv
// Sized load/store front-end for the 64-bit byte-addressed data memory.
// Sub-doubleword stores are merged into the old doubleword read back from memory.
module mem_access_unit #(
   parameter int unsigned MEM_BYTES   = 256,
   parameter bit          CHECK_ALIGN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic [63:0] mem_adr,
   output logic [63:0] mem_datain,
   output logic        mem_w,
   output logic        mem_r,
   input  logic [63:0] mem_dataout
);

   localparam int unsigned ADDR_W    = 64;
   localparam int unsigned RANGE_W   = ADDR_W + 1;
   localparam logic [RANGE_W-1:0] MEM_LIMIT = RANGE_W'(MEM_BYTES);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t      state_q;
   logic [1:0]  size_q;
   logic        signed_q;
   logic        write_q;
   logic [63:0] mem_adr_q;
   logic [63:0] mem_datain_q;
   logic        mem_r_q;
   logic        mem_w_q;
   logic        resp_valid_q;
   logic        resp_err_q;
   logic [63:0] resp_rdata_q;

   logic [2:0]  align_mask_c;
   logic        range_err_c;
   logic        align_err_c;

   // Load result: keep the low 8N bits, extend from bit 8N-1 when signed.
   function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] sz,
                                          input logic sgn);
      case (sz)
         2'b00:   extend = {{56{sgn & d[7]}},  d[7:0]};
         2'b01:   extend = {{48{sgn & d[15]}}, d[15:0]};
         2'b10:   extend = {{32{sgn & d[31]}}, d[31:0]};
         default: extend = d;
      endcase
   endfunction

   // Store merge: new low 8N bits over the old doubleword.
   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                         input logic [1:0] sz);
      case (sz)
         2'b00:   merge = {old[63:8],  nw[7:0]};
         2'b01:   merge = {old[63:16], nw[15:0]};
         2'b10:   merge = {old[63:32], nw[31:0]};
         default: merge = nw;
      endcase
   endfunction

   always_comb begin
      align_mask_c = 3'd0;
      case (req_size)
         2'b00:   align_mask_c = 3'd0;
         2'b01:   align_mask_c = 3'd1;
         2'b10:   align_mask_c = 3'd3;
         default: align_mask_c = 3'd7;
      endcase
   end

   // One extra bit so addresses near 2^64 cannot wrap into range.
   assign range_err_c = ({1'b0, req_addr} + RANGE_W'(8)) > MEM_LIMIT;
   assign align_err_c = CHECK_ALIGN && (|(req_addr[2:0] & align_mask_c));

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_adr    = mem_adr_q;
   assign mem_datain = mem_datain_q;
   assign mem_r      = mem_r_q & ~rst;
   assign mem_w      = mem_w_q & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         size_q       <= 2'b00;
         signed_q     <= 1'b0;
         write_q      <= 1'b0;
         mem_adr_q    <= '0;
         mem_datain_q <= '0;
         mem_r_q      <= 1'b0;
         mem_w_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  size_q       <= req_size;
                  signed_q     <= req_signed;
                  write_q      <= req_write;
                  mem_adr_q    <= req_addr;
                  mem_datain_q <= req_wdata;
                  if (range_err_c || align_err_c) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= '0;
                  end else if (req_write && (req_size == 2'b11)) begin
                     state_q <= WRITE;
                     mem_w_q <= 1'b1;
                  end else begin
                     state_q <= READ;
                     mem_r_q <= 1'b1;
                  end
               end
            end
            READ: begin
               mem_r_q <= 1'b0;
               if (write_q) begin
                  mem_datain_q <= merge(mem_dataout, mem_datain_q, size_q);
                  mem_w_q      <= 1'b1;
                  state_q      <= WRITE;
               end else begin
                  resp_rdata_q <= extend(mem_dataout, size_q, signed_q);
                  resp_err_q   <= 1'b0;
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end
            end
            WRITE: begin
               mem_w_q      <= 1'b0;
               resp_rdata_q <= '0;
               resp_err_q   <= 1'b0;
               resp_valid_q <= 1'b1;
               state_q      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit against a 256-byte behavioural memory.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic [63:0] mem_adr;
   logic [63:0] mem_datain;
   logic        mem_w;
   logic        mem_r;
   logic [63:0] mem_dataout;

   int vectors     = 0;
   int miscompares = 0;
   int w_cnt       = 0;
   int r_cnt       = 0;
   int both_cnt    = 0;
   logic [63:0] last_wdata = '0;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          lat;
      string       name;
   } exp_t;
   exp_t sb[$];

   logic [7:0] mem [256];

   always #5 clk = ~clk;

   mem_access_unit #(.MEM_BYTES(256), .CHECK_ALIGN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_adr(mem_adr),
      .mem_datain(mem_datain), .mem_w(mem_w), .mem_r(mem_r),
      .mem_dataout(mem_dataout)
   );

   // Combinational memory read port.
   always_comb begin
      mem_dataout = '0;
      if (mem_r)
         for (int i = 0; i < 8; i++)
            mem_dataout[8*i +: 8] = mem[8'(mem_adr) + 8'(i)];
   end

   always @(posedge clk) begin
      if (mem_w) begin
         for (int i = 0; i < 8; i++)
            mem[8'(mem_adr) + 8'(i)] <= mem_datain[8*i +: 8];
         w_cnt++;
         last_wdata = mem_datain;
      end
      if (mem_r) r_cnt++;
      if (mem_r && mem_w) both_cnt++;
   end

   task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [63:0] a, input logic [63:0] wd);
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL issue_ready: got %b want 1", req_ready);
      end
      req_valid  = 1'b1;
      req_write  = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [63:0] a, input logic [63:0] wd,
                       input logic [63:0] exp_rd, input logic exp_err,
                       input int lat, input string nm);
      exp_t e;
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.lat   = lat;
      e.name  = nm;
      sb.push_back(e);
      issue(w, sz, sg, a, wd);
   endtask

   task automatic collect(input logic ack);
      exp_t e;
      int   cyc = 0;
      while (cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (resp_valid === 1'b1) break;
      end
      if (sb.size() == 0) begin
         vectors++; miscompares++;
         $display("FAIL scoreboard_empty: response with nothing expected");
         return;
      end
      e = sb.pop_front();
      vectors++;
      if (resp_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_timeout: no resp_valid within %0d cycles", e.name, cyc);
         return;
      end
      vectors++;
      if (resp_rdata !== e.rdata) begin
         miscompares++;
         $display("FAIL %s_rdata: got %h want %h", e.name, resp_rdata, e.rdata);
      end
      vectors++;
      if (resp_err !== e.err) begin
         miscompares++;
         $display("FAIL %s_err: got %b want %b", e.name, resp_err, e.err);
      end
      vectors++;
      if (cyc != e.lat) begin
         miscompares++;
         $display("FAIL %s_latency: got %0d want %0d", e.name, cyc, e.lat);
      end
      if (ack) begin
         @(posedge clk);
         #1;
         vectors++;
         if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_release: valid %b ready %b want 0 1", e.name, resp_valid, req_ready);
         end
      end
   endtask

   task automatic check_idle_outputs(input string nm);
      vectors++;
      if ({req_ready, resp_valid, resp_err, mem_w, mem_r} !== 5'b10000) begin
         miscompares++;
         $display("FAIL %s_flags: rdy/vld/err/w/r got %b want 10000", nm,
                  {req_ready, resp_valid, resp_err, mem_w, mem_r});
      end
      vectors++;
      if (resp_rdata !== 64'h0 || mem_adr !== 64'h0 || mem_datain !== 64'h0) begin
         miscompares++;
         $display("FAIL %s_data: rdata %h adr %h din %h want all 0", nm,
                  resp_rdata, mem_adr, mem_datain);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset");
   endtask

   task automatic test_loads();
      int w0 = w_cnt;
      send(1'b0, 2'b11, 1'b0, 64'h10, '0, 64'h1716151413121110, 1'b0, 2, "ld_d_10");
      collect(1'b1);
      send(1'b0, 2'b00, 1'b1, 64'h80, '0, 64'hFFFFFFFFFFFFFF80, 1'b0, 2, "ld_b_s_80");
      collect(1'b1);
      send(1'b0, 2'b00, 1'b0, 64'h80, '0, 64'h0000000000000080, 1'b0, 2, "ld_b_u_80");
      collect(1'b1);
      send(1'b0, 2'b11, 1'b0, 64'hF8, '0, 64'hFFFEFDFCFBFAF9F8, 1'b0, 2, "ld_d_top");
      collect(1'b1);
      vectors++;
      if (w_cnt != w0) begin
         miscompares++;
         $display("FAIL loads_no_write: got %0d writes want 0", w_cnt - w0);
      end
   endtask

   task automatic test_sub_store();
      int w0 = w_cnt;
      send(1'b1, 2'b01, 1'b0, 64'h20, 64'h0000_0000_0000_BEEF, 64'h0, 1'b0, 3, "st_h_20");
      collect(1'b1);
      vectors++;
      if (w_cnt != w0 + 1 || last_wdata !== 64'h272625242322BEEF) begin
         miscompares++;
         $display("FAIL st_h_datain: writes %0d data %h want 1 272625242322beef",
                  w_cnt - w0, last_wdata);
      end
      send(1'b0, 2'b11, 1'b0, 64'h20, '0, 64'h272625242322BEEF, 1'b0, 2, "ld_d_20");
      collect(1'b1);
      send(1'b1, 2'b00, 1'b0, 64'h31, 64'hFFFF_FFFF_FFFF_FFA5, 64'h0, 1'b0, 3, "st_b_31");
      collect(1'b1);
      send(1'b0, 2'b10, 1'b1, 64'h30, '0, 64'h000000003332A530, 1'b0, 2, "ld_w_s_30");
      collect(1'b1);
      send(1'b0, 2'b01, 1'b1, 64'h30, '0, 64'hFFFFFFFFFFFFA530, 1'b0, 2, "ld_h_s_30");
      collect(1'b1);
   endtask

   task automatic test_errors();
      int w0 = w_cnt;
      int r0 = r_cnt;
      send(1'b0, 2'b10, 1'b0, 64'h22, '0, 64'h0, 1'b1, 1, "err_align");
      collect(1'b1);
      send(1'b0, 2'b11, 1'b0, 64'hF9, '0, 64'h0, 1'b1, 1, "err_range");
      collect(1'b1);
      send(1'b1, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1, 64'h0, 1'b1, 1, "err_wrap");
      collect(1'b1);
      vectors++;
      if (w_cnt != w0 || r_cnt != r0) begin
         miscompares++;
         $display("FAIL err_no_mem: reads %0d writes %0d want 0 0", r_cnt - r0, w_cnt - w0);
      end
   endtask

   task automatic test_back_to_back();
      resp_ready = 1'b0;
      send(1'b0, 2'b11, 1'b0, 64'h10, '0, 64'h1716151413121110, 1'b0, 2, "hold_ld");
      collect(1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== 64'h1716151413121110) begin
            miscompares++;
            $display("FAIL hold_stable: cyc %0d vld %b rdy %b rdata %h want 1 0 1716151413121110",
                     i, resp_valid, req_ready, resp_rdata);
         end
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL hold_release: vld %b rdy %b want 0 1", resp_valid, req_ready);
      end
      send(1'b0, 2'b00, 1'b0, 64'h11, '0, 64'h11, 1'b0, 2, "after_hold");
      collect(1'b1);
   endtask

   task automatic test_reset_mid_write();
      int w0 = w_cnt;
      resp_ready = 1'b1;
      issue(1'b1, 2'b11, 1'b0, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_idle_outputs("rst_mid");
      vectors++;
      if (w_cnt != w0) begin
         miscompares++;
         $display("FAIL rst_mid_no_write: got %0d writes want 0", w_cnt - w0);
      end
      rst = 1'b0;
      send(1'b0, 2'b11, 1'b0, 64'h40, '0, 64'h4746454443424140, 1'b0, 2, "ld_d_40");
      collect(1'b1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      resp_ready = 1'b1;
      test_reset();
      test_loads();
      test_sub_store();
      test_errors();
      test_back_to_back();
      test_reset_mid_write();
      vectors++;
      if (both_cnt != 0) begin
         miscompares++;
         $display("FAIL r_w_exclusive: %0d cycles with both asserted want 0", both_cnt);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
